// File: rtl/framing_pkg.sv
// framing_pkg: shared constants and types for the framing block RX drain engine.
//   - byte addresses of the framing block registers and RX buffers
//   - bit positions inside the STATUS register
//   - drain_state_e: states of the drain FSM
//   - rx_last_keep(): byte mask for the final beat of a frame
package framing_pkg;

  localparam logic [14:0] FR_STATUS_A   = 15'h1830;
  localparam logic [14:0] FR_RXLEN_A    = 15'h1840;
  localparam logic [14:0] FR_RXBUF_A    = 15'h4000;
  localparam logic [14:0] FR_BUF_STRIDE = 15'h0800;

  localparam int unsigned ST_FB_LSB    = 0;
  localparam int unsigned ST_NB_LSB    = 4;
  localparam int unsigned ST_LB_LSB    = 8;
  localparam int unsigned ST_AVAIL_BIT = 12;
  localparam int unsigned ST_IRQ_BIT   = 13;

  typedef enum logic [3:0] {
    S_IDLE,
    S_STAT,
    S_STAT_W,
    S_LEN,
    S_LEN_W,
    S_DATA,
    S_DATA_W,
    S_HOLD,
    S_REL
  } drain_state_e;

  // A remainder of 0 means the last word is completely filled.
  function automatic logic [7:0] rx_last_keep(input logic [2:0] rem);
    return (rem == 3'd0) ? 8'hFF : ~(8'hFF << rem);
  endfunction

endpackage

// File: rtl/framing_rx_drain.sv
// framing_rx_drain: bus-initiator that empties the framing block RX ring.
// Polls STATUS every POLL_INTERVAL idle cycles; when a frame is available it
// reads its length and data words over the LSU-style slave port (single
// outstanding access, read data one cycle after the strobe), streams the data
// as 64-bit little-endian beats, then releases the buffer by writing
// firstbuf+1 back to STATUS.
// Ports:
//   msoc_clk, rst_int_n            clock, asynchronous active-low reset
//   enable                         0 = finish current frame then stay idle
//   lsu_addr/lsu_wdata/lsu_be      access address, write data, byte enables
//   ce_d/we_d/framing_sel          access strobe, write qualifier, select
//   framing_rdata                  read data
//   m_tdata/m_tkeep/m_tlast/
//   m_tvalid/m_tready              frame output stream
//   busy                           FSM not idle
//   pkt_count/drop_count           streamed / zero-length frame counters
module framing_rx_drain
  import framing_pkg::*;
#(
  parameter int unsigned POLL_INTERVAL = 64,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             msoc_clk,
  input  logic             rst_int_n,
  input  logic             enable,
  output logic [14:0]      lsu_addr,
  output logic [63:0]      lsu_wdata,
  output logic [7:0]       lsu_be,
  output logic             ce_d,
  output logic             we_d,
  output logic             framing_sel,
  input  logic [63:0]      framing_rdata,
  output logic [63:0]      m_tdata,
  output logic [7:0]       m_tkeep,
  output logic             m_tlast,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int unsigned PT_W = $clog2(POLL_INTERVAL);
  localparam logic [PT_W-1:0] POLL_LAST = PT_W'(POLL_INTERVAL - 1);

  drain_state_e state, state_nxt;

  logic [PT_W-1:0] poll_cnt;
  logic [3:0]      fb;
  logic [10:0]     len;
  logic [8:0]      words;
  logic [7:0]      w;
  logic            poll_exp;
  logic            last_word;
  logic            beat_acc;
  logic [11:0]     len_sum;

  assign poll_exp  = (poll_cnt == POLL_LAST);
  assign last_word = ({1'b0, w} == (words - 9'd1));
  assign beat_acc  = m_tvalid && m_tready;
  assign len_sum   = {1'b0, framing_rdata[10:0]} + 12'd7;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge msoc_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    lsu_addr    = '0;
    lsu_wdata   = '0;
    lsu_be      = '0;
    ce_d        = 1'b0;
    we_d        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (poll_exp && enable) state_nxt = S_STAT;
      end
      S_STAT: begin
        ce_d      = 1'b1;
        lsu_be    = 8'hFF;
        lsu_addr  = FR_STATUS_A;
        state_nxt = S_STAT_W;
      end
      S_STAT_W: begin
        state_nxt = framing_rdata[ST_AVAIL_BIT] ? S_LEN : S_IDLE;
      end
      S_LEN: begin
        ce_d      = 1'b1;
        lsu_be    = 8'hFF;
        lsu_addr  = FR_RXLEN_A + {9'd0, fb[2:0], 3'd0};
        state_nxt = S_LEN_W;
      end
      S_LEN_W: begin
        state_nxt = (framing_rdata[10:0] == 11'd0) ? S_REL : S_DATA;
      end
      S_DATA: begin
        ce_d      = 1'b1;
        lsu_be    = 8'hFF;
        lsu_addr  = FR_RXBUF_A + 15'(fb[2:0]) * FR_BUF_STRIDE + {4'd0, w, 3'd0};
        state_nxt = S_DATA_W;
      end
      S_DATA_W: begin
        state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (beat_acc) state_nxt = last_word ? S_REL : S_DATA;
      end
      S_REL: begin
        ce_d      = 1'b1;
        we_d      = 1'b1;
        lsu_be    = 8'h0F;
        lsu_addr  = FR_STATUS_A;
        lsu_wdata = {60'd0, fb + 4'd1};
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign framing_sel = ce_d;

  // The poll timer saturates at expiry so a late enable starts a poll at once;
  // leaving IDLE clears it, which restarts the interval after every poll/release.
  always_ff @(posedge msoc_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      poll_cnt   <= '0;
      fb         <= '0;
      len        <= '0;
      words      <= '0;
      w          <= '0;
      m_tdata    <= '0;
      m_tkeep    <= '0;
      m_tlast    <= 1'b0;
      m_tvalid   <= 1'b0;
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      if (state == S_IDLE) begin
        if (!poll_exp) poll_cnt <= poll_cnt + 1'b1;
      end else begin
        poll_cnt <= '0;
      end

      unique case (state)
        S_STAT_W: fb <= framing_rdata[ST_FB_LSB +: 4];
        S_LEN_W: begin
          len   <= framing_rdata[10:0];
          words <= len_sum[11:3];
          w     <= '0;
          if (framing_rdata[10:0] == 11'd0) drop_count <= drop_count + 1'b1;
        end
        S_DATA_W: begin
          m_tdata  <= framing_rdata;
          m_tkeep  <= last_word ? rx_last_keep(len[2:0]) : 8'hFF;
          m_tlast  <= last_word;
          m_tvalid <= 1'b1;
        end
        S_HOLD: begin
          if (beat_acc) begin
            m_tvalid <= 1'b0;
            if (last_word) pkt_count <= pkt_count + 1'b1;
            else           w <= w + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_framing_rx_drain.sv
// tb_framing_rx_drain: directed and randomized frames against a behavioural
// model of the framing block slave and of the expected access/beat sequence.
`define CHK(TAG, OBS, EXP) \
  begin \
    checks++; \
    assert ((OBS) === (EXP)) else begin \
      errors++; \
      $error("FAIL %s: observed=%0h expected=%0h", TAG, OBS, EXP); \
    end \
  end

module tb_framing_rx_drain;

  localparam int POLL = 64;

  logic        msoc_clk = 1'b0;
  logic        rst_int_n = 1'b1;
  logic        enable = 1'b0;
  logic [14:0] lsu_addr;
  logic [63:0] lsu_wdata;
  logic [7:0]  lsu_be;
  logic        ce_d, we_d, framing_sel;
  logic [63:0] framing_rdata = '0;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tlast, m_tvalid;
  logic        m_tready = 1'b1;
  logic        busy;
  logic [15:0] pkt_count, drop_count;

  framing_rx_drain #(.POLL_INTERVAL(POLL), .CNT_W(16)) dut (
    .msoc_clk(msoc_clk), .rst_int_n(rst_int_n), .enable(enable),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_be(lsu_be),
    .ce_d(ce_d), .we_d(we_d), .framing_sel(framing_sel),
    .framing_rdata(framing_rdata),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .busy(busy), .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always #5 msoc_clk = ~msoc_clk;

  // Slave model state, owned by the main initial block.
  logic [63:0] mem [0:7][0:255];
  logic [10:0] rxlen [0:7];
  logic [3:0]  st_fb = '0;
  logic        st_avail = 1'b0;

  int errors = 0;
  int checks = 0;
  int exp_pkt = 0;
  int exp_drop = 0;
  int last_rel_cyc = 0;

  function automatic logic [63:0] rd_model(input logic [14:0] a);
    logic [63:0] junk;
    junk = {$urandom, $urandom};
    if (a == 15'h1830) return {junk[63:14], 1'b0, st_avail, 8'h00, st_fb};
    if (a >= 15'h1840 && a <= 15'h1878 && a[2:0] == 3'd0) return {junk[63:11], rxlen[a[5:3]]};
    if (a >= 15'h4000) return mem[a[13:11]][a[10:3]];
    return junk;
  endfunction

  // Read data is only meaningful the cycle after a read strobe; junk otherwise.
  int cyc = 0;
  always @(posedge msoc_clk) begin
    cyc <= cyc + 1;
    if (ce_d && !we_d) framing_rdata <= rd_model(lsu_addr);
    else               framing_rdata <= {$urandom, $urandom};
  end

  typedef struct {
    logic [14:0] addr;
    logic        we;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic        av;
    int          cyc;
  } acc_t;
  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    int          cyc;
  } beat_t;

  acc_t  acc_q[$];
  beat_t beat_q[$];
  int    n_wr = 0;
  int    n_unstable = 0;
  int    n_bus_bad = 0;
  logic  prev_ce = 1'b0, pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [63:0] pd = '0;
  logic [7:0]  pk = '0;

  always @(negedge msoc_clk) begin
    if (ce_d) begin
      acc_q.push_back('{lsu_addr, we_d, lsu_be, lsu_wdata, st_avail, cyc});
      if (we_d) n_wr <= n_wr + 1;
    end
    if ((ce_d && prev_ce) || (framing_sel !== ce_d) ||
        (!ce_d && (lsu_addr != 0 || lsu_wdata != 0 || lsu_be != 0 || we_d)))
      n_bus_bad <= n_bus_bad + 1;
    if (m_tvalid && m_tready) beat_q.push_back('{m_tdata, m_tkeep, m_tlast, cyc});
    if (pv && !pr && rst_int_n &&
        (!m_tvalid || m_tdata !== pd || m_tkeep !== pk || m_tlast !== pl))
      n_unstable <= n_unstable + 1;
    prev_ce <= ce_d;
    pv <= m_tvalid && rst_int_n;
    pr <= m_tready;
    pd <= m_tdata;
    pk <= m_tkeep;
    pl <= m_tlast;
  end

  // mode 0: ready always high; 1: random ready; 2: 20-cycle stall after
  // beat 4 with enable dropped during the stall.
  task automatic run_frame(input logic [3:0] fb, input int len, input int mode, input string tag);
    int ab, bb, w0, words, nbytes, base;
    bit stalled;
    acc_t act[$];
    logic [87:0] got, expv;
    logic [63:0] mask;
    logic [7:0]  ekeep;
    logic [3:0]  nfb;
    words = (len + 7) / 8;
    st_fb = fb;
    rxlen[fb[2:0]] = 11'(len);
    for (int w = 0; w < 256; w++) mem[fb[2:0]][w] = {$urandom, $urandom};
    ab = acc_q.size();
    bb = beat_q.size();
    w0 = n_wr;
    st_avail = 1'b1;
    enable = 1'b1;
    m_tready = 1'b1;
    stalled = 0;
    for (int ci = 0; ci < 20000 && n_wr == w0; ci++) begin
      if (mode == 1) m_tready = ($urandom_range(0, 3) != 0);
      else if (mode == 2 && !stalled && beat_q.size() - bb >= 4) begin
        stalled = 1;
        m_tready = 1'b0;
        enable = 1'b0;
        repeat (20) @(posedge msoc_clk);
        #1;
        m_tready = 1'b1;
      end
      @(posedge msoc_clk);
      #1;
    end
    st_avail = 1'b0;
    m_tready = 1'b1;
    `CHK({tag, " release_seen"}, n_wr - w0, 1)
    if (len > 0) exp_pkt++;
    else         exp_drop++;

    for (int i = ab; i < acc_q.size(); i++)
      if (!(acc_q[i].addr == 15'h1830 && !acc_q[i].we && !acc_q[i].av)) act.push_back(acc_q[i]);
    `CHK({tag, " n_access"}, act.size(), words + 3)
    nfb = fb + 4'd1;
    for (int i = 0; i < act.size() && i < words + 3; i++) begin
      got = {act[i].addr, act[i].we, act[i].be, act[i].wdata};
      if (i == 0)              expv = {15'h1830, 1'b0, 8'hFF, 64'd0};
      else if (i == 1)         expv = {15'(16'h1840 + 8 * fb[2:0]), 1'b0, 8'hFF, 64'd0};
      else if (i < words + 2)  expv = {15'(16'h4000 + 16'h800 * fb[2:0] + 8 * (i - 2)), 1'b0, 8'hFF, 64'd0};
      else                     expv = {15'h1830, 1'b1, 8'h0F, 60'd0, nfb};
      `CHK($sformatf("%s access%0d", tag, i), got, expv)
    end
    if (act.size() > 0) last_rel_cyc = act[act.size() - 1].cyc;

    `CHK({tag, " n_beats"}, beat_q.size() - bb, words)
    for (int k = 0; k < words && bb + k < beat_q.size(); k++) begin
      nbytes = (len - 8 * k >= 8) ? 8 : len - 8 * k;
      ekeep  = 8'((1 << nbytes) - 1);
      mask   = '0;
      for (int j = 0; j < nbytes; j++) mask[8 * j +: 8] = 8'hFF;
      `CHK($sformatf("%s beat%0d keep_last", tag, k), {beat_q[bb + k].keep, beat_q[bb + k].last}, {ekeep, 1'(k == words - 1)})
      `CHK($sformatf("%s beat%0d data", tag, k), beat_q[bb + k].data & mask, mem[fb[2:0]][k] & mask)
    end
    if (mode == 0 && words > 0 && beat_q.size() - bb == words && act.size() > 0) begin
      base = beat_q[bb].cyc;
      `CHK({tag, " first_beat_latency"}, base - act[0].cyc, 6)
      `CHK({tag, " beat_spacing"}, beat_q[bb + words - 1].cyc - base, 3 * (words - 1))
    end
    `CHK({tag, " pkt_count"}, pkt_count, 16'(exp_pkt))
    `CHK({tag, " drop_count"}, drop_count, 16'(exp_drop))
    `CHK({tag, " stream_stable"}, n_unstable, 0)
    `CHK({tag, " bus_protocol"}, n_bus_bad, 0)
  endtask

  initial begin
    int ab, bb, w0, ci;
    for (int i = 0; i < 8; i++) rxlen[i] = '0;

    #1 rst_int_n = 1'b0;
    #1;
    `CHK("reset_bus", {ce_d, we_d, framing_sel, lsu_addr, lsu_wdata, lsu_be}, 90'd0)
    `CHK("reset_stream", {m_tvalid, m_tlast, m_tkeep, m_tdata}, 74'd0)
    `CHK("reset_status", {busy, pkt_count, drop_count}, 33'd0)
    repeat (3) @(posedge msoc_clk);
    #1 rst_int_n = 1'b1;

    run_frame(4'h0, 60, 0, "len60_fb0");
    ab = acc_q.size();
    for (ci = 0; ci < 300 && acc_q.size() == ab; ci++) begin
      @(posedge msoc_clk);
      #1;
    end
    `CHK("poll_seen", acc_q.size() > ab, 1'b1)
    if (acc_q.size() > ab) `CHK("poll_interval", acc_q[ab].cyc - last_rel_cyc, POLL + 1)

    run_frame(4'h3, 64, 1, "len64_fb3");
    run_frame(4'hF, 8, 0, "len8_fbF");
    run_frame(4'h6, 0, 0, "len0_drop");
    run_frame(4'h2, 100, 2, "stall_disable");

    // Disabled engine must not touch the bus even with a frame pending.
    ab = acc_q.size();
    st_avail = 1'b1;
    repeat (3 * POLL) @(posedge msoc_clk);
    #1;
    `CHK("disabled_no_access", acc_q.size() - ab, 0)
    `CHK("disabled_idle", busy, 1'b0)
    st_avail = 1'b0;

    for (int r = 0; r < 4; r++)
      run_frame(4'($urandom_range(0, 15)), $urandom_range(0, 200), 1, $sformatf("rand%0d", r));

    // Reset during beat 3 of a long frame: nothing released, frame redone.
    st_fb = 4'h5;
    rxlen[5] = 11'd1500;
    for (int w = 0; w < 256; w++) mem[5][w] = {$urandom, $urandom};
    bb = beat_q.size();
    w0 = n_wr;
    m_tready = 1'b1;
    enable = 1'b1;
    st_avail = 1'b1;
    for (ci = 0; ci < 3000 && !(beat_q.size() - bb >= 3 && m_tvalid); ci++) begin
      @(posedge msoc_clk);
      #1;
    end
    `CHK("rst_beat3_reached", beat_q.size() - bb, 3)
    #2 rst_int_n = 1'b0;
    #1;
    `CHK("rst_mid_bus", {ce_d, we_d, framing_sel, lsu_addr, lsu_wdata, lsu_be}, 90'd0)
    `CHK("rst_mid_stream", {m_tvalid, m_tlast, m_tkeep, m_tdata}, 74'd0)
    `CHK("rst_mid_status", {busy, pkt_count, drop_count}, 33'd0)
    repeat (2) @(posedge msoc_clk);
    #1 rst_int_n = 1'b1;
    `CHK("rst_no_release", n_wr - w0, 0)
    exp_pkt = 0;
    exp_drop = 0;
    run_frame(4'h5, 1500, 1, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`undef CHK
